booth2_pp_sum: RTL and testbench

- Stage directly downstream of the Radix-4 Booth partial-product generator in the 8x8 signed multiplier.
- Takes the four 10-bit un-extended partial products PP1..PP4 and sign-extends and shifts them by 0/2/4/6 bits.
- Reduces them in a 2-stage registered pipeline with valid/ready flow control and outputs the 16-bit signed product.
- Sustains one product per cycle when not back-pressured.

---
 rtl/booth2_pp_sum.sv | 67 ++++++
 tb/tb_booth2_pp_sum.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth2_pp_sum.sv
// Sums the four radix-4 Booth partial products of an 8x8 signed multiply into the 16-bit product.
// Two registered stages with valid/ready flow control. Each stage holds its data while stalled.
module booth2_pp_sum #(
    parameter int PP_W  = 10,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pp_valid_i,
    output logic             pp_ready_o,
    input  logic [PP_W-1:0]  PP1,
    input  logic [PP_W-1:0]  PP2,
    input  logic [PP_W-1:0]  PP3,
    input  logic [PP_W-1:0]  PP4,
    output logic             prod_valid_o,
    input  logic             prod_ready_i,
    output logic [OUT_W-1:0] prod_o
);
    // The extra 3 bits absorb PPa + 4*PPb without overflow.
    localparam int S1_W = PP_W + 3;

    logic            v1, v2, adv1, adv2;
    logic [S1_W-1:0] pp1_x, pp2_x, pp3_x, pp4_x;
    logic [S1_W-1:0] lo_sum, hi_sum, s1_lo, s1_hi;
    logic [OUT_W-1:0] lo_x, hi_x;

    assign pp1_x = {{(S1_W-PP_W){PP1[PP_W-1]}}, PP1};
    assign pp2_x = {{(S1_W-PP_W){PP2[PP_W-1]}}, PP2};
    assign pp3_x = {{(S1_W-PP_W){PP3[PP_W-1]}}, PP3};
    assign pp4_x = {{(S1_W-PP_W){PP4[PP_W-1]}}, PP4};

    assign lo_sum = pp1_x + (pp2_x << 2);
    assign hi_sum = pp3_x + (pp4_x << 2);

    assign lo_x = {{(OUT_W-S1_W){s1_lo[S1_W-1]}}, s1_lo};
    assign hi_x = {{(OUT_W-S1_W){s1_hi[S1_W-1]}}, s1_hi};

    // The ready chain is the only combinational path through the block.
    assign adv2         = !v2 || prod_ready_i;
    assign adv1         = !v1 || adv2;
    assign pp_ready_o   = adv1;
    assign prod_valid_o = v2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            s1_lo <= '0;
            s1_hi <= '0;
        end else if (adv1) begin
            v1 <= pp_valid_i;
            if (pp_valid_i) begin
                s1_lo <= lo_sum;
                s1_hi <= hi_sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2     <= 1'b0;
            prod_o <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) prod_o <= lo_x + (hi_x << 4);
        end
    end
endmodule

// File: tb/tb_booth2_pp_sum.sv
// Scoreboard bench for booth2_pp_sum. PPs come from a Booth-digit model. Expected products are plain A*B.
module tb_booth2_pp_sum;
    localparam int PP_W  = 10;
    localparam int OUT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pp_valid_i = 1'b0;
    logic             pp_ready_o;
    logic [PP_W-1:0]  PP1 = '0, PP2 = '0, PP3 = '0, PP4 = '0;
    logic             prod_valid_o;
    logic             prod_ready_i = 1'b1;
    logic [OUT_W-1:0] prod_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;      // 0: always ready, 1: random, 2: never ready
    bit chk_lat = 1'b0;
    int acc_cnt = 0;
    int out_cnt = 0;
    logic [OUT_W-1:0] exp_q[$];
    int               acc_q[$];

    booth2_pp_sum #(.PP_W(PP_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst),
        .pp_valid_i(pp_valid_i), .pp_ready_o(pp_ready_o),
        .PP1(PP1), .PP2(PP2), .PP3(PP3), .PP4(PP4),
        .prod_valid_o(prod_valid_o), .prod_ready_i(prod_ready_i),
        .prod_o(prod_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Radix-4 Booth recoding: digit k = -2*b[2k+1] + b[2k] + b[2k-1], PPk = digit*A.
    function automatic logic [4*PP_W-1:0] booth(input logic signed [7:0] a, input logic signed [7:0] b);
        logic [8:0] bx;
        logic [4*PP_W-1:0] r;
        int d, pp;
        bx = {b, 1'b0};
        r = '0;
        for (int k = 0; k < 4; k++) begin
            d  = -2 * int'(bx[2*k+2]) + int'(bx[2*k+1]) + int'(bx[2*k]);
            pp = d * int'(a);
            r[k*PP_W +: PP_W] = pp[PP_W-1:0];
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       prod_ready_i = 1'b1;
            1:       prod_ready_i = 1'($urandom_range(1));
            default: prod_ready_i = 1'b0;
        endcase
    end

    // Called at posedge+1. Returns at posedge+1 with pp_valid_i low.
    task automatic send(input logic signed [7:0] a, input logic signed [7:0] b);
        logic [4*PP_W-1:0] pps;
        logic [31:0]       prod;
        int                n;
        bit                ok;
        pps  = booth(a, b);
        prod = int'(a) * int'(b);
        {PP4, PP3, PP2, PP1} = pps;
        pp_valid_i = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 500) begin
            @(negedge clk);
            if (pp_ready_o) ok = 1'b1;
            else begin
                n++;
                @(posedge clk);
                #1;
            end
        end
        if (ok) begin
            exp_q.push_back(prod[OUT_W-1:0]);
            acc_q.push_back(cyc);
            acc_cnt++;
        end else check("accept_timeout", 32'(n), 32'(0));
        @(posedge clk);
        #1;
        pp_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each output transfer and checks stalled outputs hold steady.
    initial begin
        logic             held;
        logic [OUT_W-1:0] held_val, e;
        int               c;
        held = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            if (rst) held = 1'b0;
            else begin
                if (prod_valid_o && held) check("stall_hold", 32'(prod_o), 32'(held_val));
                if (prod_valid_o && prod_ready_i) begin
                    if (exp_q.size() == 0) check("unexpected_out", 32'(prod_o), 32'hFFFF_FFFF);
                    else begin
                        e = exp_q.pop_front();
                        c = acc_q.pop_front();
                        check("prod", 32'(prod_o), 32'(e));
                        if (chk_lat) check("latency", 32'(cyc - c), 32'(2));
                        else if (cyc - c < 2) check("min_latency", 32'(cyc - c), 32'(2));
                        out_cnt++;
                    end
                end
                held     = prod_valid_o && !prod_ready_i;
                held_val = prod_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_prod_valid", 32'(prod_valid_o), 32'(0));
        check("rst_prod", 32'(prod_o), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(pp_ready_o), 32'(1));
        @(posedge clk);
        #1;

        // Directed cases, free-flowing output
        chk_lat = 1'b1;
        send(8'sd5, 8'sd3);
        wait_drain();
        send(-8'sd128, -8'sd128);
        send(8'sd127, -8'sd128);
        wait_drain();

        // Back-to-back stream of 20
        for (int i = 0; i < 20; i++) send(8'($urandom), 8'($urandom));
        wait_drain();

        // Output stalled while three inputs are offered
        chk_lat  = 1'b0;
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(8'($urandom), 8'($urandom));
        send(8'($urandom), 8'($urandom));
        fork
            send(-8'sd7, 8'sd9);
        join_none
        @(negedge clk);
        check("pp_ready_full", 32'(pp_ready_o), 32'(0));
        repeat (3) @(negedge clk);
        rdy_mode = 0;
        wait fork;
        wait_drain();

        // Random valid/ready toggling
        rdy_mode = 1;
        acc_cnt  = 0;
        out_cnt  = 0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom), 8'($urandom));
        end
        rdy_mode = 0;
        wait_drain();
        check("accept_vs_output", 32'(acc_cnt), 32'(out_cnt));

        // Reset with both stages full
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(8'sd11, 8'sd13);
        send(-8'sd20, 8'sd6);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_prod_valid", 32'(prod_valid_o), 32'(0));
        check("midrst_prod", 32'(prod_o), 32'(0));
        exp_q.delete();
        acc_q.delete();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_lat = 1'b1;
        send(8'sd3, 8'sd2);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
